// File: rtl/gpreg_pkg.sv
// Shared APCPU register-file definitions: memory opcodes and default bus widths.
// The sequencer and the ALU use these too.
package gpreg_pkg;

  localparam int GP_DATA_W = 32;
  localparam int GP_ADDR_W = 3;

  typedef enum logic [1:0] {
    MEM_NOP = 2'b00,
    MEM_RD  = 2'b01,
    MEM_WR  = 2'b10,
    MEM_REG = 2'b11
  } mem_op_e;

endpackage

// File: rtl/gp_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by a reservation, cleared by a committed write.
// Set wins over clear so that a new producer keeps the register pending.
module gp_scoreboard
  import gpreg_pkg::*;
#(
  parameter int ADDR_W   = GP_ADDR_W,
  parameter int DEPTH    = 2**ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_sel,
  input  logic [DEPTH-1:0]  clr,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      // The hardwired zero register can never be reserved.
      localparam bit SET_OK = (ZERO_REG == 0) || (gi != 0);

      assign busy_next[gi] = (SET_OK && set_en && (set_sel == ADDR_W'(gi)))
                           | (busy_reg[gi] & ~clr[gi]);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_reg[gi] <= 1'b0;
        end else begin
          busy_reg[gi] <= busy_next[gi];
        end
      end
    end
  endgenerate

  assign busy = busy_reg;

endmodule

// File: rtl/gp_regfile.sv
// General-purpose register file: two registered read ports, memory and ALU write-back ports,
// optional write-first bypass, optional hardwired zero register, and a busy scoreboard.
module gp_regfile
  import gpreg_pkg::*;
#(
  parameter int DATA_W   = GP_DATA_W,
  parameter int ADDR_W   = GP_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    sel_x,
  input  logic [ADDR_W-1:0]    sel_y,
  input  logic [ADDR_W-1:0]    sel_z,
  input  logic [1:0]           mem_op,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic                 alu_we,
  input  logic [ADDR_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_sel,
  output logic [DATA_W-1:0]    a,
  output logic [DATA_W-1:0]    b,
  output logic                 a_valid,
  output logic                 b_valid,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              mem_wr;
  logic              alu_wr;
  logic [DEPTH-1:0]  wr_mask;

  // The ALU write is dropped when memory targets the same register.
  always_comb begin
    mem_wr = (mem_op == MEM_REG) && !((ZERO_REG != 0) && (sel_z == '0));
    alu_wr = alu_we && !((ZERO_REG != 0) && (alu_sel == '0))
                    && !(mem_wr && (alu_sel == sel_z));
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic mem_hit;
      logic alu_hit;

      assign mem_hit     = mem_wr && (sel_z == ADDR_W'(gi));
      assign alu_hit     = alu_wr && (alu_sel == ADDR_W'(gi));
      assign wr_mask[gi] = mem_hit | alu_hit;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs[gi] <= '0;
        end else if (mem_hit) begin
          regs[gi] <= mem_data;
        end else if (alu_hit) begin
          regs[gi] <= alu_data;
        end
      end
    end
  endgenerate

  logic [ADDR_W-1:0] rd_sel   [2];
  logic [DATA_W-1:0] rd_reg   [2];
  logic              vld_reg  [2];

  assign rd_sel[0] = sel_x;
  assign rd_sel[1] = sel_y;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              hit_mem;
      logic              hit_alu;
      logic [DATA_W-1:0] rd_next;
      logic              vld_next;

      assign hit_mem = mem_wr && (rd_sel[gi] == sel_z);
      assign hit_alu = alu_wr && (rd_sel[gi] == alu_sel);

      always_comb begin
        rd_next = regs[rd_sel[gi]];
        if (BYPASS != 0) begin
          if (hit_mem) begin
            rd_next = mem_data;
          end else if (hit_alu) begin
            rd_next = alu_data;
          end
        end
        if ((ZERO_REG != 0) && (rd_sel[gi] == '0)) begin
          rd_next = '0;
        end
        // Validity uses the pre-edge busy bit, so a same-cycle reservation is not seen.
        vld_next = !busy[rd_sel[gi]] || ((BYPASS != 0) && (hit_mem || hit_alu));
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_reg[gi]  <= '0;
          vld_reg[gi] <= 1'b0;
        end else begin
          rd_reg[gi]  <= rd_next;
          vld_reg[gi] <= vld_next;
        end
      end
    end
  endgenerate

  assign a       = rd_reg[0];
  assign b       = rd_reg[1];
  assign a_valid = vld_reg[0];
  assign b_valid = vld_reg[1];

  gp_scoreboard #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (rsv_en),
    .set_sel (rsv_sel),
    .clr     (wr_mask),
    .busy    (busy)
  );

endmodule

// File: tb/tb_gp_regfile.sv
// Bench for gp_regfile: four instances covering BYPASS x ZERO_REG, all fed the same stimulus
// and checked every cycle against an array-based model of the register file.
module tb_gp_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel_x, sel_y, sel_z, alu_sel, rsv_sel;
  logic [1:0]  mem_op;
  logic [31:0] mem_data, alu_data;
  logic        alu_we, rsv_en;

  // Instance c: BYPASS = (c is even), ZERO_REG = (c >= 2).
  logic [31:0] a_o  [4];
  logic [31:0] b_o  [4];
  logic        av_o [4];
  logic        bv_o [4];
  logic [7:0]  bz_o [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      gp_regfile #(
        .DATA_W   (32),
        .ADDR_W   (3),
        .BYPASS   (((gi % 2) == 0) ? 1 : 0),
        .ZERO_REG ((gi >= 2) ? 1 : 0)
      ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_x    (sel_x),
        .sel_y    (sel_y),
        .sel_z    (sel_z),
        .mem_op   (mem_op),
        .mem_data (mem_data),
        .alu_we   (alu_we),
        .alu_sel  (alu_sel),
        .alu_data (alu_data),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .a        (a_o[gi]),
        .b        (b_o[gi]),
        .a_valid  (av_o[gi]),
        .b_valid  (bv_o[gi]),
        .busy     (bz_o[gi])
      );
    end
  endgenerate

  // Reference model state
  logic [31:0] m_regs [4][8];
  logic [7:0]  m_busy [4];
  logic [31:0] e_a [4];
  logic [31:0] e_b [4];
  logic        e_av [4];
  logic        e_bv [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) m_regs[c][r] = '0;
      m_busy[c] = '0;
      e_a[c] = '0; e_b[c] = '0; e_av[c] = 1'b0; e_bv[c] = 1'b0;
    end
  endtask

  // One clock edge as described by the register-file rules.
  task automatic model_edge();
    logic [31:0] nr [8];
    logic [7:0]  wm;
    logic        byp, z;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 4; c++) begin
      byp = (c % 2) == 0;
      z   = c >= 2;
      for (int r = 0; r < 8; r++) nr[r] = m_regs[c][r];
      wm = '0;
      // ALU first, memory second: memory wins on a shared target.
      if (alu_we && !(z && alu_sel == 3'd0)) begin nr[alu_sel] = alu_data; wm[alu_sel] = 1'b1; end
      if (mem_op == 2'b11 && !(z && sel_z == 3'd0)) begin nr[sel_z] = mem_data; wm[sel_z] = 1'b1; end
      e_a[c]  = (z && sel_x == 3'd0) ? 32'd0 : (byp ? nr[sel_x] : m_regs[c][sel_x]);
      e_b[c]  = (z && sel_y == 3'd0) ? 32'd0 : (byp ? nr[sel_y] : m_regs[c][sel_y]);
      e_av[c] = !m_busy[c][sel_x] || (byp && wm[sel_x]);
      e_bv[c] = !m_busy[c][sel_y] || (byp && wm[sel_y]);
      m_busy[c] = m_busy[c] & ~wm;
      if (rsv_en && !(z && rsv_sel == 3'd0)) m_busy[c][rsv_sel] = 1'b1;
      for (int r = 0; r < 8; r++) m_regs[c][r] = nr[r];
    end
  endtask

  task automatic check_all(input string step);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s a[%0d]", step, c),  64'(a_o[c]),  64'(e_a[c]));
      chk($sformatf("%s b[%0d]", step, c),  64'(b_o[c]),  64'(e_b[c]));
      chk($sformatf("%s av[%0d]", step, c), 64'(av_o[c]), 64'(e_av[c]));
      chk($sformatf("%s bv[%0d]", step, c), 64'(bv_o[c]), 64'(e_bv[c]));
      chk($sformatf("%s busy[%0d]", step, c), 64'(bz_o[c]), 64'(m_busy[c]));
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle(input string step);
    model_edge();
    @(posedge clk);
    #1;
    check_all(step);
    $display("[TB] %s sel_x=%0d sel_y=%0d mem_op=%0d sel_z=%0d alu_we=%0d alu_sel=%0d rsv=%0d/%0d a0=%h",
             step, sel_x, sel_y, mem_op, sel_z, alu_we, alu_sel, rsv_en, rsv_sel, a_o[0]);
    @(negedge clk);
  endtask

  task automatic idle();
    mem_op = 2'b00; alu_we = 1'b0; rsv_en = 1'b0;
  endtask

  // Asynchronous reset asserted mid-phase while the current inputs request writes.
  task automatic async_reset(input string step);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all({step, "_async"});
    @(posedge clk);
    #1;
    check_all({step, "_held"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    sel_x = '0; sel_y = '0; sel_z = '0; alu_sel = '0; rsv_sel = '0;
    mem_op = '0; mem_data = '0; alu_we = 1'b0; alu_data = '0; rsv_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_all("init");

    // Reset in the middle of a write of 0xDEADBEEF to r3
    mem_op = 2'b11; sel_z = 3'd3; mem_data = 32'hDEADBEEF; sel_x = 3'd3; rsv_en = 1'b1; rsv_sel = 3'd3;
    async_reset("rst");
    idle();
    cycle("rst_read");
    chk("rst_read_a", 64'(a_o[0]), 64'd0);
    chk("rst_read_av", 64'(av_o[0]), 64'd1);
    chk("rst_read_busy", 64'(bz_o[0]), 64'd0);

    // Write then read, same cycle
    mem_op = 2'b11; sel_z = 3'd5; mem_data = 32'h12345678; sel_x = 3'd5;
    cycle("wr_rd");
    chk("wr_rd_byp1", 64'(a_o[0]), 64'h12345678);
    chk("wr_rd_byp0", 64'(a_o[1]), 64'd0);
    idle();
    cycle("wr_rd2");
    chk("wr_rd2_byp0", 64'(a_o[1]), 64'h12345678);

    // Write collision
    mem_op = 2'b11; sel_z = 3'd2; mem_data = 32'hAAAA0000;
    alu_we = 1'b1; alu_sel = 3'd2; alu_data = 32'h5555FFFF;
    cycle("collide");
    idle(); sel_x = 3'd2;
    cycle("collide_rd");
    chk("collide_r2", 64'(a_o[1]), 64'hAAAA0000);

    // Dual write
    mem_op = 2'b11; sel_z = 3'd2; mem_data = 32'hAAAA0000;
    alu_we = 1'b1; alu_sel = 3'd4; alu_data = 32'h5555FFFF;
    cycle("dual");
    idle(); sel_x = 3'd2; sel_y = 3'd4;
    cycle("dual_rd");
    chk("dual_r2", 64'(a_o[1]), 64'hAAAA0000);
    chk("dual_r4", 64'(b_o[1]), 64'h5555FFFF);

    // Scoreboard
    rsv_en = 1'b1; rsv_sel = 3'd6;
    cycle("rsv6");
    chk("rsv6_busy", 64'(bz_o[0][6]), 64'd1);
    idle(); sel_x = 3'd6;
    cycle("rsv6_rd");
    chk("rsv6_av", 64'(av_o[0]), 64'd0);
    alu_we = 1'b1; alu_sel = 3'd6; alu_data = 32'h77;
    cycle("rsv6_wr");
    chk("rsv6_wr_busy", 64'(bz_o[0][6]), 64'd0);
    chk("rsv6_wr_a", 64'(a_o[0]), 64'h77);
    chk("rsv6_wr_av", 64'(av_o[0]), 64'd1);
    rsv_en = 1'b1; rsv_sel = 3'd6; alu_we = 1'b1; alu_sel = 3'd6; alu_data = 32'h88;
    cycle("rsv6_both");
    chk("rsv6_both_busy", 64'(bz_o[0][6]), 64'd1);
    idle();
    rsv_en = 1'b1; rsv_sel = 3'd6;
    cycle("rsv6_again");
    chk("rsv6_again_busy", 64'(bz_o[0][6]), 64'd1);

    // Zero register
    idle();
    mem_op = 2'b11; sel_z = 3'd0; mem_data = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_sel = 3'd0; sel_x = 3'd0;
    cycle("zero_wr");
    idle();
    cycle("zero_rd");
    chk("zero_z1_a", 64'(a_o[2]), 64'd0);
    chk("zero_z1_busy", 64'(bz_o[2][0]), 64'd0);
    chk("zero_z0_a", 64'(a_o[0]), 64'hFFFFFFFF);

    // Randomised traffic with one mid-run asynchronous reset
    for (int i = 0; i < 300; i++) begin
      sel_x    = 3'($urandom_range(0, 7));
      sel_y    = 3'($urandom_range(0, 7));
      sel_z    = 3'($urandom_range(0, 7));
      alu_sel  = 3'($urandom_range(0, 7));
      rsv_sel  = 3'($urandom_range(0, 7));
      mem_op   = 2'($urandom_range(0, 3));
      mem_data = $urandom;
      alu_data = $urandom;
      alu_we   = 1'($urandom_range(0, 1));
      rsv_en   = ($urandom_range(0, 3) == 0);
      if (i == 150) begin
        async_reset("rnd_rst");
      end else begin
        cycle($sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
